// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, partial-write (ppp) encodings and their legality check.
package cpu_pkg;

    localparam int DATA_W = 64;
    localparam int REG_AW = 5;
    localparam int PPP_W  = 3;

    // Bit ranges use big-endian numbering, so "HI" is [0:31].
    localparam logic [PPP_W-1:0] PPP_FULL = 3'b000;
    localparam logic [PPP_W-1:0] PPP_HI   = 3'b001;
    localparam logic [PPP_W-1:0] PPP_LO   = 3'b010;
    localparam logic [PPP_W-1:0] PPP_EVEN = 3'b011;
    localparam logic [PPP_W-1:0] PPP_ODD  = 3'b100;

    function automatic logic ppp_legal(input logic [PPP_W-1:0] ppp);
        return (ppp <= PPP_ODD);
    endfunction

endpackage

// File: rtl/wb_fwd_cmp.sv
// One-source forward compare: flags that the ID source will find its producer in WB next cycle.
module wb_fwd_cmp
    import cpu_pkg::*;
#(
    parameter int AW = cpu_pkg::REG_AW
) (
    input  logic             id_r_i,
    input  logic [AW-1:0]    id_reg_i,
    input  logic [AW-1:0]    ex_rd_i,
    input  logic             ex_wren_i,
    input  logic             ex_stall_i,
    input  logic [PPP_W-1:0] ex_ppp_i,
    output logic             fwd_o
);

    // r0 never forwards; illegal ppp never writes, so it never forwards either.
    assign fwd_o = id_r_i & ex_wren_i & ~ex_stall_i & (ex_rd_i != '0)
                 & (id_reg_i == ex_rd_i) & ppp_legal(ex_ppp_i);

endmodule

// File: rtl/exmem_wb_stage.sv
// EXMEM->WB pipeline register: selects ALU/load data, qualifies the regfile write,
// inserts bubbles on EXMEM stall, drives forward flags and counts retired slots.
module exmem_wb_stage #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int REG_AW = cpu_pkg::REG_AW,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              EXMEM_stall,
    input  logic [0:DATA_W-1] EXMEM_ALU_out,
    input  logic [0:DATA_W-1] dmem_data_out,
    input  logic              EXMEM_rD_data_select,
    input  logic [REG_AW-1:0] EXMEM_rD,
    input  logic [2:0]        EXMEM_ppp,
    input  logic              EXMEM_wrEn,
    input  logic [REG_AW-1:0] ID_rA,
    input  logic [REG_AW-1:0] ID_rB,
    input  logic              ID_rA_used,
    input  logic              ID_rB_used,
    input  logic              cnt_clr,
    output logic [0:DATA_W-1] WB_data,
    output logic [2:0]        WB_ppp,
    output logic [REG_AW-1:0] WB_rD,
    output logic              WB_wrEn,
    output logic              WB_valid,
    output logic              fwd_rA,
    output logic              fwd_rB,
    output logic [CNT_W-1:0]  retire_count
);
    import cpu_pkg::*;

    logic [0:DATA_W-1] data_q, data_d;
    logic [2:0]        ppp_q, ppp_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              wren_q, wren_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    wb_fwd_cmp #(.AW(REG_AW)) u_fwd_a (
        .id_r_i    (ID_rA_used),
        .id_reg_i  (ID_rA),
        .ex_rd_i   (EXMEM_rD),
        .ex_wren_i (EXMEM_wrEn),
        .ex_stall_i(EXMEM_stall),
        .ex_ppp_i  (EXMEM_ppp),
        .fwd_o     (fwd_rA)
    );

    wb_fwd_cmp #(.AW(REG_AW)) u_fwd_b (
        .id_r_i    (ID_rB_used),
        .id_reg_i  (ID_rB),
        .ex_rd_i   (EXMEM_rD),
        .ex_wren_i (EXMEM_wrEn),
        .ex_stall_i(EXMEM_stall),
        .ex_ppp_i  (EXMEM_ppp),
        .fwd_o     (fwd_rB)
    );

    // A bubble clears the control fields but leaves data/ppp as they were.
    always_comb begin
        data_d  = data_q;
        ppp_d   = ppp_q;
        rd_d    = '0;
        wren_d  = 1'b0;
        valid_d = 1'b0;
        cnt_d   = cnt_q;
        if (!EXMEM_stall) begin
            data_d  = EXMEM_rD_data_select ? dmem_data_out : EXMEM_ALU_out;
            ppp_d   = EXMEM_ppp;
            rd_d    = EXMEM_rD;
            wren_d  = EXMEM_wrEn & (EXMEM_rD != '0) & ppp_legal(EXMEM_ppp);
            valid_d = 1'b1;
            cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (cnt_clr) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            ppp_q   <= '0;
            rd_q    <= '0;
            wren_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            ppp_q   <= ppp_d;
            rd_q    <= rd_d;
            wren_q  <= wren_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign WB_data      = data_q;
    assign WB_ppp       = ppp_q;
    assign WB_rD        = rd_q;
    assign WB_wrEn      = wren_q;
    assign WB_valid     = valid_q;
    assign retire_count = cnt_q;

endmodule

// File: tb/tb_exmem_wb_stage.sv
// Directed bench for exmem_wb_stage: expected WB state queued per driven step, popped after the edge.
module tb_exmem_wb_stage;

    logic        clk;
    logic        reset;
    logic        EXMEM_stall;
    logic [0:63] EXMEM_ALU_out;
    logic [0:63] dmem_data_out;
    logic        EXMEM_rD_data_select;
    logic [4:0]  EXMEM_rD;
    logic [2:0]  EXMEM_ppp;
    logic        EXMEM_wrEn;
    logic [4:0]  ID_rA, ID_rB;
    logic        ID_rA_used, ID_rB_used;
    logic        cnt_clr;
    logic [0:63] WB_data;
    logic [2:0]  WB_ppp;
    logic [4:0]  WB_rD;
    logic        WB_wrEn, WB_valid, fwd_rA, fwd_rB;
    logic [31:0] retire_count;

    // Narrow-counter instance to exercise wraparound in a few cycles.
    logic        stall_w, clr_w;
    logic [0:63] w_data;
    logic [2:0]  w_ppp;
    logic [4:0]  w_rd;
    logic        w_we, w_vld, w_fa, w_fb;
    logic [1:0]  w_cnt;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [63:0] data;
        logic [2:0]  ppp;
        logic [4:0]  rd;
        logic        we;
        logic        vld;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    exmem_wb_stage dut (
        .clk(clk), .reset(reset), .EXMEM_stall(EXMEM_stall),
        .EXMEM_ALU_out(EXMEM_ALU_out), .dmem_data_out(dmem_data_out),
        .EXMEM_rD_data_select(EXMEM_rD_data_select), .EXMEM_rD(EXMEM_rD),
        .EXMEM_ppp(EXMEM_ppp), .EXMEM_wrEn(EXMEM_wrEn),
        .ID_rA(ID_rA), .ID_rB(ID_rB), .ID_rA_used(ID_rA_used), .ID_rB_used(ID_rB_used),
        .cnt_clr(cnt_clr), .WB_data(WB_data), .WB_ppp(WB_ppp), .WB_rD(WB_rD),
        .WB_wrEn(WB_wrEn), .WB_valid(WB_valid), .fwd_rA(fwd_rA), .fwd_rB(fwd_rB),
        .retire_count(retire_count)
    );

    exmem_wb_stage #(.CNT_W(2)) dut_w (
        .clk(clk), .reset(reset), .EXMEM_stall(stall_w),
        .EXMEM_ALU_out(64'h0), .dmem_data_out(64'h0),
        .EXMEM_rD_data_select(1'b0), .EXMEM_rD(5'd1),
        .EXMEM_ppp(3'b000), .EXMEM_wrEn(1'b1),
        .ID_rA(5'd0), .ID_rB(5'd0), .ID_rA_used(1'b0), .ID_rB_used(1'b0),
        .cnt_clr(clr_w), .WB_data(w_data), .WB_ppp(w_ppp), .WB_rD(w_rd),
        .WB_wrEn(w_we), .WB_valid(w_vld), .fwd_rA(w_fa), .fwd_rB(w_fb),
        .retire_count(w_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".data"},  WB_data,      64'h0);
        chk({tag, ".ppp"},   WB_ppp,       64'h0);
        chk({tag, ".rd"},    WB_rD,        64'h0);
        chk({tag, ".we"},    WB_wrEn,      64'h0);
        chk({tag, ".vld"},   WB_valid,     64'h0);
        chk({tag, ".cnt"},   retire_count, 64'h0);
    endtask

    // Drive one step at negedge, check forward flags, queue the expected WB state,
    // then compare it against the DUT shortly after the capturing edge.
    task automatic step(input string tag,
                        input logic st, input logic sel, input logic [63:0] alu,
                        input logic [63:0] dmem, input logic [4:0] rd, input logic [2:0] ppp,
                        input logic we, input logic [4:0] ra, input logic rau,
                        input logic [4:0] rb, input logic rbu, input logic clr,
                        input logic e_fa, input logic e_fb,
                        input logic [63:0] e_data, input logic [2:0] e_ppp, input logic [4:0] e_rd,
                        input logic e_we, input logic e_vld, input logic [31:0] e_cnt);
        exp_t e;
        @(negedge clk);
        EXMEM_stall = st; EXMEM_rD_data_select = sel; EXMEM_ALU_out = alu;
        dmem_data_out = dmem; EXMEM_rD = rd; EXMEM_ppp = ppp; EXMEM_wrEn = we;
        ID_rA = ra; ID_rA_used = rau; ID_rB = rb; ID_rB_used = rbu; cnt_clr = clr;
        #1;
        chk({tag, ".fwd_rA"}, fwd_rA, e_fa);
        chk({tag, ".fwd_rB"}, fwd_rB, e_fb);
        e.data = e_data; e.ppp = e_ppp; e.rd = e_rd; e.we = e_we; e.vld = e_vld; e.cnt = e_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".data"}, WB_data,      e.data);
        chk({tag, ".ppp"},  WB_ppp,       e.ppp);
        chk({tag, ".rd"},   WB_rD,        e.rd);
        chk({tag, ".we"},   WB_wrEn,      e.we);
        chk({tag, ".vld"},  WB_valid,     e.vld);
        chk({tag, ".cnt"},  retire_count, e.cnt);
    endtask

    initial begin
        reset = 1'b0; EXMEM_stall = 1'b1; EXMEM_ALU_out = '0; dmem_data_out = '0;
        EXMEM_rD_data_select = 1'b0; EXMEM_rD = '0; EXMEM_ppp = '0; EXMEM_wrEn = 1'b0;
        ID_rA = '0; ID_rB = '0; ID_rA_used = 1'b0; ID_rB_used = 1'b0; cnt_clr = 1'b0;
        stall_w = 1'b1; clr_w = 1'b0;
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // ALU op
        step("alu", 0, 0, 64'h0123_4567_89AB_CDEF, 0, 3, 3'b000, 1, 0, 0, 0, 0, 0,
             0, 0, 64'h0123_4567_89AB_CDEF, 3'b000, 3, 1, 1, 1);
        // Load: two bubbles then the load data
        step("ld_b1", 1, 1, 64'h0, 64'h0, 5, 3'b000, 1, 5, 1, 0, 0, 0,
             0, 0, 64'h0123_4567_89AB_CDEF, 3'b000, 0, 0, 0, 1);
        step("ld_b2", 1, 1, 64'h0, 64'h0, 5, 3'b000, 1, 5, 1, 0, 0, 0,
             0, 0, 64'h0123_4567_89AB_CDEF, 3'b000, 0, 0, 0, 1);
        step("ld_wr", 0, 1, 64'hFFFF_0000_FFFF_0000, 64'hDEAD_BEEF_0000_0001, 5, 3'b000, 1, 5, 1, 0, 0, 0,
             1, 0, 64'hDEAD_BEEF_0000_0001, 3'b000, 5, 1, 1, 2);
        // r0 and ppp boundaries
        step("r0", 0, 0, 64'hAAAA_AAAA_AAAA_AAAA, 0, 0, 3'b000, 1, 0, 1, 0, 1, 0,
             0, 0, 64'hAAAA_AAAA_AAAA_AAAA, 3'b000, 0, 0, 1, 3);
        step("ppp110", 0, 0, 64'h5555_5555_5555_5555, 0, 4, 3'b110, 1, 4, 1, 0, 0, 0,
             0, 0, 64'h5555_5555_5555_5555, 3'b110, 4, 0, 1, 4);
        step("ppp100", 0, 0, 64'h0F0F_0F0F_0F0F_0F0F, 0, 9, 3'b100, 1, 0, 0, 9, 1, 0,
             0, 1, 64'h0F0F_0F0F_0F0F_0F0F, 3'b100, 9, 1, 1, 5);
        step("store", 0, 0, 64'h1234, 0, 2, 3'b000, 0, 2, 1, 0, 0, 0,
             0, 0, 64'h1234, 3'b000, 2, 0, 1, 6);
        // Forwarding
        step("fwd", 0, 0, 64'h7777, 0, 7, 3'b000, 1, 7, 1, 7, 0, 0,
             1, 0, 64'h7777, 3'b000, 7, 1, 1, 7);
        step("fwd_st", 1, 0, 64'h7777, 0, 7, 3'b000, 1, 7, 1, 7, 0, 0,
             0, 0, 64'h7777, 3'b000, 0, 0, 0, 7);
        step("fwd_b", 0, 0, 64'h7070, 0, 7, 3'b000, 1, 7, 0, 7, 1, 0,
             0, 1, 64'h7070, 3'b000, 7, 1, 1, 8);
        // Async reset in the middle of a load
        step("pre_rst", 0, 0, 64'h1111_1111_1111_1111, 0, 8, 3'b001, 1, 0, 0, 0, 0, 0,
             0, 0, 64'h1111_1111_1111_1111, 3'b001, 8, 1, 1, 9);
        step("rst_b1", 1, 1, 64'h0, 64'h0, 12, 3'b000, 1, 0, 0, 0, 0, 0,
             0, 0, 64'h1111_1111_1111_1111, 3'b001, 0, 0, 0, 9);
        @(negedge clk);
        EXMEM_stall = 1'b1;
        #2 reset = 1'b0;
        #1 chk_all_zero("async_rst");
        @(negedge clk);
        reset = 1'b1;
        step("post_rst", 0, 0, 64'h2222_2222_2222_2222, 0, 10, 3'b000, 1, 0, 0, 0, 0, 0,
             0, 0, 64'h2222_2222_2222_2222, 3'b000, 10, 1, 1, 1);
        // Counter clear priority
        step("clr_cap", 0, 0, 64'h3333, 0, 11, 3'b000, 1, 0, 0, 0, 0, 1,
             0, 0, 64'h3333, 3'b000, 11, 1, 1, 0);
        step("cnt_inc", 0, 0, 64'h4444, 0, 11, 3'b000, 1, 0, 0, 0, 0, 0,
             0, 0, 64'h4444, 3'b000, 11, 1, 1, 1);
        step("clr_st", 1, 0, 64'h0, 0, 11, 3'b000, 1, 0, 0, 0, 0, 1,
             0, 0, 64'h4444, 3'b000, 0, 0, 0, 0);

        // Wraparound on the 2-bit counter: 3 is the maximum, then 0, then 1
        @(negedge clk);
        stall_w = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            #1 chk($sformatf("wrap%0d", i), w_cnt, 64'(i % 4));
        end
        @(negedge clk);
        stall_w = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
